// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage pipeline sequencer for the PC and the IF/ID register.
// Freezes the front end on load-use hazards and data-memory waits, flushes the
// IF/ID slot after taken branches/jumps, and keeps saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYC = 1,
  parameter int FLUSH_CYC      = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_hold,
  output logic             if_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // rem only ever holds (cycles - 1), so the wider of the two lengths sets its width
  localparam int MAX_CYC = (LOAD_STALL_CYC > FLUSH_CYC) ? LOAD_STALL_CYC : FLUSH_CYC;
  localparam int REM_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
  localparam logic [REM_W-1:0] LOAD_REM  = REM_W'(LOAD_STALL_CYC - 1);
  localparam logic [REM_W-1:0] FLUSH_REM = REM_W'(FLUSH_CYC - 1);
  localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc;
  logic             flush_inc;
  logic             hazard;
  logic             redirect;

  assign hazard = idex_mem_read && (idex_rt != 5'd0) &&
                  ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign redirect = branch_taken | jump;

  // Next-state and same-cycle control decode; reset and mem_busy override everything
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b1;
    ifid_hold   = 1'b0;
    if_flush    = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_hold   = 1'b1;
      if_flush    = 1'b0;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      // whole front end frozen; state and rem hold so the sequence resumes afterwards
      pc_write    = 1'b0;
      ifid_hold   = 1'b1;
      stall_inc   = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            // a redirect seen now is re-evaluated once the load has cleared
            pc_write    = 1'b0;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = STALL;
              rem_d   = LOAD_REM;
            end else begin
              state_d = RUN;
            end
          end else if (redirect) begin
            ifid_hold = 1'b1;
            if_flush  = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_d = FLUSH;
              rem_d   = FLUSH_REM;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        STALL: begin
          pc_write    = 1'b0;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
          rem_d       = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = RUN;
          end else begin
            state_d = STALL;
          end
        end
        FLUSH: begin
          // the slot being flushed is squashed, so its branch/jump is not honoured
          ifid_hold = 1'b1;
          if_flush  = 1'b1;
          rem_d     = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = RUN;
          end else begin
            state_d = FLUSH;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Saturating increment of the performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, remaining-cycle and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
